button_debounce: RTL

Debounces one asynchronous push-button input and turns it into a clean level plus single-cycle press, release and long-press event pulses. It sits on the input side of the board-level user interface, opposite the LED blink indicators. Its pulses are meant to drive control logic and indicator `trigger` inputs directly. It also keeps a wrapping press counter for status readout.

---
 rtl/button_debounce.sv | 111 +++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer, restart-on-glitch debounce counter,
// registered press/release/long-press pulses and a wrapping press counter.
module button_debounce #(
  parameter int   COUNTER_WIDTH      = 20,
  parameter int   LONG_COUNTER_WIDTH = 26,
  parameter logic ACTIVE_LOW         = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count
);

  // Event outputs are fire-and-forget single-cycle pulses: no valid/ready,
  // consumers sample every cycle.
  typedef enum logic {ST_RELEASED = 1'b0, ST_PRESSED = 1'b1} state_t;

  localparam logic                          RAW_RELEASED = ACTIVE_LOW;
  localparam logic [COUNTER_WIDTH-1:0]      DB_ONE       = 1;
  localparam logic [LONG_COUNTER_WIDTH-1:0] HOLD_ONE     = 1;
  localparam logic [LONG_COUNTER_WIDTH-1:0] HOLD_PRE     = {{(LONG_COUNTER_WIDTH-1){1'b1}}, 1'b0};

  state_t                        state_q, state_d;
  logic                          sync1_q, sync2_q;
  logic                          sync_p;
  logic                          accept;
  logic [COUNTER_WIDTH-1:0]      db_cnt_q, db_cnt_d;
  logic [LONG_COUNTER_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                          press_q, press_d;
  logic                          release_q, release_d;
  logic                          long_q, long_d;
  logic [7:0]                    press_count_q, press_count_d;

  // sync_p is 1 when the synchronized button reads as pressed.
  assign sync_p    = sync2_q ^ ACTIVE_LOW;
  assign btn_level = (state_q == ST_PRESSED);
  assign accept    = (sync_p != btn_level) && (db_cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RELEASED: if (accept) state_d = ST_PRESSED;
      ST_PRESSED:  if (accept) state_d = ST_RELEASED;
      default:     state_d = ST_RELEASED;
    endcase
  end

  // A release accepted on the same edge as the long threshold suppresses btn_long.
  always_comb begin
    db_cnt_d      = db_cnt_q + DB_ONE;
    hold_cnt_d    = '0;
    press_d       = 1'b0;
    release_d     = 1'b0;
    long_d        = 1'b0;
    press_count_d = press_count_q;
    if ((sync_p == btn_level) || accept) begin
      db_cnt_d = '0;
    end
    if (accept && (state_q == ST_RELEASED)) begin
      press_d       = 1'b1;
      press_count_d = press_count_q + 8'd1;
    end
    if (accept && (state_q == ST_PRESSED)) begin
      release_d = 1'b1;
    end
    if ((state_q == ST_PRESSED) && !accept) begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
      long_d     = (hold_cnt_q == HOLD_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= RAW_RELEASED;
      sync2_q       <= RAW_RELEASED;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      sync1_q       <= btn_in;
      sync2_q       <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      press_q       <= press_d;
      release_q     <= release_d;
      long_q        <= long_d;
      press_count_q <= press_count_d;
    end
  end

  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign press_count = press_count_q;

endmodule
